// File: rtl/bure_stage_if_pkg.sv
// Shared types and constants for the bure instruction-fetch stage.
// Holds the FSM encoding, the sequential PC step and the request-counter width.
package bure_stage_if_pkg;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_e;

    localparam int PC_INC = 4;
    localparam int CNT_W  = 8;

endpackage

// File: rtl/bure_stage_if_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect from
// execute and the decode handshake. master = fetch stage, slave = environment.
interface bure_stage_if_if #(
    parameter int INSTR_WIDTH = 32
);

    logic                   o_imem_req;
    logic [INSTR_WIDTH-1:0] o_imem_addr;
    logic                   i_imem_gnt;
    logic                   i_imem_rvalid;
    logic [INSTR_WIDTH-1:0] i_imem_rdata;
    logic                   i_redirect_valid;
    logic [INSTR_WIDTH-1:0] i_redirect_pc;
    logic                   o_instr_valid;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [INSTR_WIDTH-1:0] o_pc;
    logic                   i_instr_ready;

    modport master (
        output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  i_redirect_valid, i_redirect_pc, i_instr_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output i_redirect_valid, i_redirect_pc, i_instr_ready
    );

endinterface

// File: rtl/bure_fifo.sv
// Small power-of-two circular buffer with push, pop, synchronous flush and count.
// The head entry is presented combinationally on o_rdata; storage is not reset.
module bure_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = i_pop && (count_q != '0);
        // A push into a full buffer is legal only when the head leaves in the same cycle.
        do_push = i_push && !i_flush && ((count_q != FULL) || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/bure_stage_if.sv
// Instruction-fetch stage: credit-limited in-order fetch into a small buffer,
// with redirect flush and dropping of responses that belong to the old path.
module bure_stage_if
    import bure_stage_if_pkg::*;
#(
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                     FIFO_DEPTH  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    bure_stage_if_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = 2 * INSTR_WIDTH;
    localparam logic [INSTR_WIDTH-1:0] PC_STEP = INSTR_WIDTH'(PC_INC);
    localparam logic [CNT_W-1:0]       CREDITS = CNT_W'(FIFO_DEPTH);

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, redirect_tgt;
    logic [CNT_W-1:0]       os_q, os_d, drop_q, drop_d, live;
    logic [CW-1:0]          fifo_count;
    logic [FW-1:0]          fifo_rdata;
    logic                   req, fire, push, pop, flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        // os_q counts every granted-but-unanswered request; live excludes the doomed ones.
        live         = os_q - drop_q;
        req          = (state_q == ST_RUN) && ((live + CNT_W'(fifo_count)) < CREDITS)
                       && (os_q != '1);
        fire         = req && bus.i_imem_gnt;
        pop          = (fifo_count != '0) && bus.i_instr_ready;
        redirect_tgt = bus.i_redirect_pc & ~INSTR_WIDTH'(3);
        os_d         = os_q + CNT_W'(fire) - CNT_W'(bus.i_imem_rvalid);
        pc_d         = fire ? pc_q + PC_STEP : pc_q;
        drop_d       = drop_q;
        resp_pc_d    = resp_pc_q;
        push         = 1'b0;
        flush        = 1'b0;
        if (bus.i_redirect_valid) begin
            // Everything still outstanding after this edge, including this cycle's grant, is stale.
            flush     = 1'b1;
            pc_d      = redirect_tgt;
            resp_pc_d = redirect_tgt;
            drop_d    = os_d;
        end else if (bus.i_imem_rvalid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                push      = 1'b1;
                resp_pc_d = resp_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            os_q      <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            os_q      <= os_d;
            drop_q    <= drop_d;
        end
    end

    bure_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (flush),
        .i_wdata ({bus.i_imem_rdata, resp_pc_q}),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count)
    );

    assign bus.o_imem_req    = req;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_instr_valid = (fifo_count != '0);
    assign bus.o_instr       = fifo_rdata[FW-1:INSTR_WIDTH];
    assign bus.o_pc          = fifo_rdata[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_bure_stage_if.sv
// Bench for bure_stage_if: a queue-based model of fetched, dropped and buffered
// instructions drives randomized memory/decode behaviour and checks each cycle.
module tb_bure_stage_if;

    localparam int FIFO_DEPTH = 2;

    logic clk;
    logic rst;

    bure_stage_if_if #(.INSTR_WIDTH(32)) bus ();
    bure_stage_if_if #(.INSTR_WIDTH(32)) bus2 ();

    bure_stage_if #(
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0000_0000),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    bure_stage_if #(
        .INSTR_WIDTH (32),
        .RESET_PC    (32'hFFFF_FFFC),
        .FIFO_DEPTH  (2)
    ) dut_wrap (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          p_gnt, p_rv, p_rdy;
    logic [31:0] os_addr[$];
    bit          os_stale[$];
    logic [31:0] buf_pc[$];
    logic [31:0] hs_log[$];
    logic [31:0] gnt_log[$];
    logic [31:0] m_pc;
    bit          m_run;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // One clock: compare outputs with the model, pick inputs, advance the model.
    task automatic step(input bit redir, input logic [31:0] tgt);
        int          live;
        bit          exp_req, exp_vld, gnt, rv, rdy, s;
        logic [31:0] a;
        live = 0;
        foreach (os_stale[i]) if (!os_stale[i]) live++;
        exp_req = m_run && ((live + buf_pc.size()) < FIFO_DEPTH);
        exp_vld = (buf_pc.size() != 0);
        checks++;
        if (bus.o_imem_req !== exp_req) begin
            errors++;
            $display("FAIL imem_req got %b exp %b at %0t", bus.o_imem_req, exp_req, $time);
        end
        if (exp_req) begin
            checks++;
            if (bus.o_imem_addr !== m_pc) begin
                errors++;
                $display("FAIL imem_addr got %h exp %h at %0t", bus.o_imem_addr, m_pc, $time);
            end
        end
        checks++;
        if (bus.o_instr_valid !== exp_vld) begin
            errors++;
            $display("FAIL instr_valid got %b exp %b at %0t", bus.o_instr_valid, exp_vld, $time);
        end
        if (exp_vld) begin
            checks++;
            if (bus.o_pc !== buf_pc[0] || bus.o_instr !== mem_word(buf_pc[0])) begin
                errors++;
                $display("FAIL head got pc %h instr %h exp pc %h instr %h at %0t",
                         bus.o_pc, bus.o_instr, buf_pc[0], mem_word(buf_pc[0]), $time);
            end
        end
        gnt = ($urandom_range(99) < p_gnt);
        rv  = (os_addr.size() != 0) && ($urandom_range(99) < p_rv);
        rdy = ($urandom_range(99) < p_rdy);
        bus.i_imem_gnt       = gnt;
        bus.i_imem_rvalid    = rv;
        bus.i_imem_rdata     = rv ? mem_word(os_addr[0]) : $urandom;
        bus.i_redirect_valid = redir;
        bus.i_redirect_pc    = redir ? tgt : $urandom;
        bus.i_instr_ready    = rdy;
        if (bus.o_imem_req && gnt) gnt_log.push_back(bus.o_imem_addr);
        if (exp_vld && rdy) hs_log.push_back(buf_pc.pop_front());
        if (rv) begin
            a = os_addr.pop_front();
            s = os_stale.pop_front();
            if (!s && !redir) buf_pc.push_back(a);
        end
        if (exp_req && gnt) begin
            os_addr.push_back(m_pc);
            os_stale.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            foreach (os_stale[i]) os_stale[i] = 1'b1;
            buf_pc.delete();
            m_pc = {tgt[31:2], 2'b00};
        end
        m_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.i_imem_gnt       = 1'b0;
        bus.i_imem_rvalid    = 1'b0;
        bus.i_imem_rdata     = '0;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;
        bus.i_instr_ready    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        os_addr.delete();
        os_stale.delete();
        buf_pc.delete();
        hs_log.delete();
        gnt_log.delete();
        m_pc  = 32'h0;
        m_run = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got req %b vld %b exp 0 0", bus.o_imem_req, bus.o_instr_valid);
        end
        p_gnt = 100; p_rv = 100; p_rdy = 50;
        repeat (6) step(1'b0, 32'h0);
        reset_dut();
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got req %b vld %b exp 0 0", bus.o_imem_req, bus.o_instr_valid);
        end
    endtask

    task automatic test_sequential();
        reset_dut();
        p_gnt = 100; p_rv = 100; p_rdy = 100;
        step(1'b0, 32'h0);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req got req %b addr %h exp 1 00000000", bus.o_imem_req, bus.o_imem_addr);
        end
        repeat (14) step(1'b0, 32'h0);
        checks++;
        if (hs_log.size() < 3 || hs_log[0] !== 32'h0 || hs_log[1] !== 32'h4 || hs_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL seq_pc got %0d entries exp pcs 0 4 8", hs_log.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        reset_dut();
        p_gnt = 100; p_rv = 100; p_rdy = 0;
        repeat (4) step(1'b0, 32'h0);
        held = bus.o_instr;
        repeat (10) step(1'b0, 32'h0);
        checks++;
        if (gnt_log.size() != 2) begin
            errors++;
            $display("FAIL bp_grants got %0d exp 2", gnt_log.size());
        end
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_instr_valid !== 1'b1 || bus.o_instr !== held
            || bus.o_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold got req %b vld %b instr %h pc %h exp 0 1 %h 00000000",
                     bus.o_imem_req, bus.o_instr_valid, bus.o_instr, bus.o_pc, held);
        end
        p_rdy = 100;
        repeat (8) step(1'b0, 32'h0);
        checks++;
        if (hs_log.size() < 2 || hs_log[0] !== 32'h0 || hs_log[1] !== 32'h4) begin
            errors++;
            $display("FAIL bp_drain got %0d entries exp pcs 0 4", hs_log.size());
        end
    endtask

    task automatic test_redirect();
        reset_dut();
        p_gnt = 100; p_rv = 0; p_rdy = 100;
        repeat (4) step(1'b0, 32'h0);
        checks++;
        if (gnt_log.size() != 2) begin
            errors++;
            $display("FAIL redir_inflight got %0d exp 2", gnt_log.size());
        end
        gnt_log.delete();
        hs_log.delete();
        step(1'b1, 32'h0000_0103);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h100 || bus.o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_addr got req %b addr %h vld %b exp 1 00000100 0",
                     bus.o_imem_req, bus.o_imem_addr, bus.o_instr_valid);
        end
        p_rv = 100;
        repeat (10) step(1'b0, 32'h0);
        checks++;
        if (gnt_log.size() == 0 || hs_log.size() == 0 || gnt_log[0] !== 32'h100 || hs_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL redir_first got %0d grants %0d instrs exp first pc 00000100",
                     gnt_log.size(), hs_log.size());
        end
    endtask

    task automatic test_redirect_gnt_rvalid();
        reset_dut();
        p_gnt = 100; p_rv = 0; p_rdy = 100;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        p_rv = 100;
        gnt_log.delete();
        hs_log.delete();
        step(1'b1, 32'h0000_0040);
        checks++;
        if (gnt_log.size() != 1 || gnt_log[0] !== 32'h4 || bus.o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rgr_cycle got grants %0d vld %b exp 1 grant of 00000004 vld 0",
                     gnt_log.size(), bus.o_instr_valid);
        end
        repeat (10) step(1'b0, 32'h0);
        checks++;
        if (hs_log.size() == 0 || hs_log[0] !== 32'h40) begin
            errors++;
            $display("FAIL rgr_first got %0d instrs exp first pc 00000040", hs_log.size());
        end
        foreach (hs_log[i]) begin
            checks++;
            if (hs_log[i] < 32'h40) begin
                errors++;
                $display("FAIL rgr_stale got pc %h exp none below 00000040", hs_log[i]);
            end
        end
    endtask

    task automatic test_gnt_delay();
        reset_dut();
        p_gnt = 0; p_rv = 100; p_rdy = 100;
        step(1'b0, 32'h0);
        repeat (3) begin
            checks++;
            if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0) begin
                errors++;
                $display("FAIL wait_addr got req %b addr %h exp 1 00000000", bus.o_imem_req, bus.o_imem_addr);
            end
            step(1'b0, 32'h0);
        end
        step(1'b1, 32'h0002_0007);
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0002_0004) begin
            errors++;
            $display("FAIL wait_retarget got req %b addr %h exp 1 00020004", bus.o_imem_req, bus.o_imem_addr);
        end
        p_gnt = 100;
        repeat (6) step(1'b0, 32'h0);
        checks++;
        if (hs_log.size() == 0 || hs_log[0] !== 32'h0002_0004) begin
            errors++;
            $display("FAIL wait_first got %0d instrs exp first pc 00020004", hs_log.size());
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        checks++;
        if (bus2.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_boot got req %b exp 0", bus2.o_imem_req);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus2.o_imem_req !== 1'b1 || bus2.o_imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first got req %b addr %h exp 1 fffffffc", bus2.o_imem_req, bus2.o_imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus2.o_imem_req !== 1'b1 || bus2.o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second got req %b addr %h exp 1 00000000", bus2.o_imem_req, bus2.o_imem_addr);
        end
    endtask

    task automatic test_random();
        bit redir;
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                p_gnt = $urandom_range(100, 20);
                p_rv  = $urandom_range(100, 20);
                p_rdy = $urandom_range(100, 0);
            end
            if (i % 750 == 749) reset_dut();
            redir = ($urandom_range(99) < 4);
            step(redir, $urandom);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus2.i_imem_gnt       = 1'b1;
        bus2.i_imem_rvalid    = 1'b0;
        bus2.i_imem_rdata     = '0;
        bus2.i_redirect_valid = 1'b0;
        bus2.i_redirect_pc    = '0;
        bus2.i_instr_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_gnt_rvalid();
        test_gnt_delay();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bure_stage_if.md
BURE_STAGE_IF -- requirements
Module: bure_stage_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, meaning the instruction and PC width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction buffer entries (power of 2, ≥2).
REQ-004 SHALL have port i_clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port o_imem_req, output, 1: instruction fetch request valid.
REQ-007 SHALL have port o_imem_addr, output, INSTR_WIDTH: fetch address, word-aligned.
REQ-008 SHALL have port i_imem_gnt, input, 1: request accepted this cycle.
REQ-009 SHALL have port i_imem_rvalid, input, 1: response valid; responses in order, ≥1 cycle after gnt.
REQ-010 SHALL have port i_imem_rdata, input, INSTR_WIDTH: response instruction word.
REQ-011 SHALL have port i_redirect_valid, input, 1: control-flow redirect from execute.
REQ-012 SHALL have port i_redirect_pc, input, INSTR_WIDTH: redirect target; bits [1:0] ignored.
REQ-013 SHALL have port o_instr_valid, output, 1: instruction available to decode (feeds decode instr_valid).
REQ-014 SHALL have port o_instr, output, INSTR_WIDTH: instruction to decode.
REQ-015 SHALL have port o_pc, output, INSTR_WIDTH: PC of o_instr.
REQ-016 SHALL have port i_instr_ready, input, 1: decode accepts; transfer occurs when o_instr_valid && i_instr_ready.

Function
REQ-017 SHALL use FSM states BOOT (one cycle after reset, no request) and RUN; BOOT->RUN unconditionally, RUN->BOOT only on reset.
REQ-018 SHALL assert o_imem_req in RUN only when inflight + fifo_count < FIFO_DEPTH, counting only non-dropped inflight requests (credit rule; the FIFO never overflows).
REQ-019 SHALL hold o_imem_addr stable while o_imem_req=1 and i_imem_gnt=0, except on redirect.
REQ-020 SHALL advance the fetch PC by 4 on each gnt; the PC wraps modulo 2^INSTR_WIDTH.
REQ-021 SHALL push {rdata, pc} into the FIFO on non-dropped rvalid, with the pc tracked per request in order.
REQ-022 SHALL present the FIFO head on o_instr/o_pc with o_instr_valid = (fifo_count != 0); bypassing is not allowed, so the minimum rvalid->o_instr_valid latency is 1 cycle.
REQ-023 SHALL hold o_instr/o_pc stable while o_instr_valid=1 and i_instr_ready=0.
REQ-024 On redirect, SHALL flush the FIFO, set the fetch PC to {i_redirect_pc[31:2],2'b00} next cycle, and set drop_cnt to all requests in flight after this cycle, including one granted this cycle.
REQ-025 SHALL decrement drop_cnt on each rvalid while drop_cnt>0, discarding that data; the FIFO is not written.
REQ-026 On redirect with a pending ungranted request, SHALL retarget the request to the new PC next cycle; an ungranted request is not counted as in flight.
REQ-027 When redirect coincides with rvalid, SHALL discard that response; when it coincides with a decode handshake, SHALL let the flush win (o_instr_valid=0 next cycle).
REQ-028 SHALL allow simultaneous push and pop when the FIFO is full or empty; push+pop on full keeps the count unchanged.
REQ-029 SHALL allow a new request in the same cycle as a redirect only to the new PC, i.e., from the next cycle.

Reset
REQ-030 SHALL on i_rst=1 set state=BOOT, PC=RESET_PC, fifo_count=0, inflight=0, drop_cnt=0, o_imem_req=0, o_instr_valid=0; o_instr/o_pc need no reset.
REQ-031 SHALL, if reset asserts mid-transaction, require memory responses to prior requests not to arrive after reset; the bench enforces this.

Structure
REQ-032 SHALL place the FSM state enum and the PC increment constant (4) in a shared package used by the core stages.
REQ-033 SHALL implement the buffer as one sub-module, bure_fifo (parameterised width/depth, push/pop/flush, count).

Verification
REQ-034 Reset, 0-wait memory, ready=1: first req at addr 0x0 in cycle 2; o_pc sequence 0x0, 0x4, 0x8 with rdata echoed.
REQ-035 Backpressure: ready=0 for 10 cycles: at most 2 instructions buffered, o_imem_req=0 once credits are exhausted, o_instr stable.
REQ-036 Redirect to 0x103 with 2 in flight: both responses dropped, next req addr 0x100, first o_pc=0x100.
REQ-037 Redirect in the same cycle as gnt and rvalid: the granted response is dropped too; no stale instruction appears.
REQ-038 gnt delayed 3 cycles: o_imem_addr constant; a redirect during the wait retargets addr next cycle.
REQ-039 RESET_PC=0xFFFF_FFFC: second fetch address wraps to 0x0.
